// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types, constants and helpers for the platform collision scanner
package collision_pkg;

   typedef enum logic [1:0] {
      NORMAL    = 2'd0,
      SPRING    = 2'd1,
      BREAKABLE = 2'd2,
      MOVING    = 2'd3
   } plat_kind_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } scan_state_e;

   localparam int DEF_HIT_Y_TOP    = 80;
   localparam int DEF_HIT_Y_BOT    = 50;
   localparam int DEF_HIT_X_L      = 61;
   localparam int DEF_HIT_X_R      = 80;
   localparam int DEF_GROUND_RST_Y = 767;

   function automatic int ceil_div(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/hitbox_check.sv
// rtl/hitbox_check.sv - combinational landing test of the doodle against one platform slot
module hitbox_check import collision_pkg::*; #(
   parameter int COORD_W   = 11,
   parameter int DX_W      = 11,
   parameter int DY_W      = 10,
   parameter int HIT_Y_TOP = DEF_HIT_Y_TOP,
   parameter int HIT_Y_BOT = DEF_HIT_Y_BOT,
   parameter int HIT_X_L   = DEF_HIT_X_L,
   parameter int HIT_X_R   = DEF_HIT_X_R
) (
   input  logic signed [COORD_W-1:0] plat_y,
   input  logic signed [COORD_W-1:0] plat_x,
   input  logic                      active,
   input  logic                      fall,
   input  logic [DX_W-1:0]           doodle_x,
   input  logic [DY_W-1:0]           doodle_y,
   output logic                      hit,
   output logic signed [COORD_W+1:0] gap
);

   // Two guard bits keep plat_y - HIT_Y_TOP from wrapping for small or negative y.
   localparam int AW = COORD_W + 2;
   localparam logic signed [AW-1:0] Y_TOP = AW'(HIT_Y_TOP);
   localparam logic signed [AW-1:0] Y_BOT = AW'(HIT_Y_BOT);
   localparam logic signed [AW-1:0] X_L   = AW'(HIT_X_L);
   localparam logic signed [AW-1:0] X_R   = AW'(HIT_X_R);

   logic signed [AW-1:0] py, px, dx, dy;

   assign py = {{(AW-COORD_W){plat_y[COORD_W-1]}}, plat_y};
   assign px = {{(AW-COORD_W){plat_x[COORD_W-1]}}, plat_x};
   assign dx = {{(AW-DX_W){1'b0}}, doodle_x};
   assign dy = {{(AW-DY_W){1'b0}}, doodle_y};

   assign hit = active && fall
             && (dy >= py - Y_TOP) && (dy <= py - Y_BOT)
             && (dx >= px - X_L)   && (dx <= px + X_R);

   // Distance from the doodle's feet to the platform top; never negative when hit is set.
   assign gap = py - Y_BOT - dy;

endmodule

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - time-multiplexed nearest-landing-platform scanner
module collision_scanner import collision_pkg::*; #(
   parameter int N_PLAT       = 93,
   parameter int LANES        = 4,
   parameter int COORD_W      = 11,
   parameter int DX_W         = 11,
   parameter int DY_W         = 10,
   parameter int HIT_Y_TOP    = DEF_HIT_Y_TOP,
   parameter int HIT_Y_BOT    = DEF_HIT_Y_BOT,
   parameter int HIT_X_L      = DEF_HIT_X_L,
   parameter int HIT_X_R      = DEF_HIT_X_R,
   parameter int GROUND_RST_Y = DEF_GROUND_RST_Y,
   localparam int IDX_W       = (N_PLAT > 1) ? $clog2(N_PLAT) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [N_PLAT-1:0][1:0][COORD_W-1:0]  platforms,
   input  logic [N_PLAT-1:0]                    platform_activation,
   input  logic [N_PLAT-1:0][1:0]               platform_kind,
   input  logic [DX_W-1:0]                      doodle_x,
   input  logic [DY_W-1:0]                      doodle_y,
   input  logic                                 doodle_fall_direction,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 collision,
   output logic [1:0][DY_W-1:0]                 ground,
   output logic [IDX_W-1:0]                     hit_index,
   output plat_kind_e                           hit_kind
);

   localparam int AW         = COORD_W + 2;
   localparam int SCAN_SLOTS = ceil_div(N_PLAT, LANES) * LANES;
   localparam int BASE_W     = $clog2(SCAN_SLOTS + 1);

   scan_state_e state_q, state_d;

   logic [BASE_W-1:0] base, base_next;
   logic              last_step;

   logic [DX_W-1:0] lat_x;
   logic [DY_W-1:0] lat_y;
   logic            lat_fall;

   logic                 best_valid, sel_valid;
   logic signed [AW-1:0] best_gap, sel_gap;
   logic [IDX_W-1:0]     best_idx, sel_idx;
   logic [DY_W-1:0]      best_y, sel_y, best_x, sel_x;
   plat_kind_e           best_kind, sel_kind;

   logic [LANES-1:0]     lane_hit;
   logic signed [AW-1:0] lane_gap [LANES];
   logic [IDX_W-1:0]     lane_idx [LANES];

   assign base_next = base + BASE_W'(LANES);
   assign last_step = base_next >= BASE_W'(N_PLAT);

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [BASE_W-1:0] slot;
      logic              in_range;

      assign slot        = base + BASE_W'(l);
      assign in_range    = slot < BASE_W'(N_PLAT);
      assign lane_idx[l] = in_range ? slot[IDX_W-1:0] : '0;

      hitbox_check #(
         .COORD_W  (COORD_W),
         .DX_W     (DX_W),
         .DY_W     (DY_W),
         .HIT_Y_TOP(HIT_Y_TOP),
         .HIT_Y_BOT(HIT_Y_BOT),
         .HIT_X_L  (HIT_X_L),
         .HIT_X_R  (HIT_X_R)
      ) u_hitbox (
         .plat_y  (platforms[lane_idx[l]][0]),
         .plat_x  (platforms[lane_idx[l]][1]),
         .active  (platform_activation[lane_idx[l]] & in_range),
         .fall    (lat_fall),
         .doodle_x(lat_x),
         .doodle_y(lat_y),
         .hit     (lane_hit[l]),
         .gap     (lane_gap[l])
      );
   end

   // Fold this cycle's lanes into the running best; strict < keeps the lower index on ties.
   always_comb begin
      sel_valid = best_valid;
      sel_gap   = best_gap;
      sel_idx   = best_idx;
      sel_y     = best_y;
      sel_x     = best_x;
      sel_kind  = best_kind;
      for (int l = 0; l < LANES; l++) begin
         if (lane_hit[l] && (!sel_valid || lane_gap[l] < sel_gap)) begin
            sel_valid = 1'b1;
            sel_gap   = lane_gap[l];
            sel_idx   = lane_idx[l];
            sel_y     = platforms[lane_idx[l]][0][DY_W-1:0];
            sel_x     = platforms[lane_idx[l]][1][DY_W-1:0];
            sel_kind  = plat_kind_e'(platform_kind[lane_idx[l]]);
         end
      end
   end

   // Next-state and status decode; start is only honoured from IDLE.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN: begin
            busy = 1'b1;
            if (last_step) state_d = FINISH;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Snapshot, scan accumulation and result publication (results land as FINISH begins).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base       <= '0;
         lat_x      <= '0;
         lat_y      <= '0;
         lat_fall   <= 1'b0;
         best_valid <= 1'b0;
         best_gap   <= '0;
         best_idx   <= '0;
         best_y     <= '0;
         best_x     <= '0;
         best_kind  <= NORMAL;
         collision  <= 1'b0;
         ground[0]  <= DY_W'(GROUND_RST_Y);
         ground[1]  <= '0;
         hit_index  <= '0;
         hit_kind   <= NORMAL;
      end else if (state_q == IDLE && start) begin
         lat_x      <= doodle_x;
         lat_y      <= doodle_y;
         lat_fall   <= doodle_fall_direction;
         base       <= '0;
         best_valid <= 1'b0;
      end else if (state_q == SCAN) begin
         base       <= base_next;
         best_valid <= sel_valid;
         best_gap   <= sel_gap;
         best_idx   <= sel_idx;
         best_y     <= sel_y;
         best_x     <= sel_x;
         best_kind  <= sel_kind;
         if (last_step) begin
            collision <= sel_valid;
            if (sel_valid) begin
               ground[0] <= sel_y;
               ground[1] <= sel_x;
               hit_index <= sel_idx;
               hit_kind  <= sel_kind;
            end
         end
      end
   end

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - self-checking bench for collision_scanner at LANES 4, 1 and 93
module tb_collision_scanner;
   import collision_pkg::*;

   localparam int N    = 93;
   localparam int CW   = 11;
   localparam int DXW  = 11;
   localparam int DYW  = 10;
   localparam int MAXN = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]               start_v = '0;
   logic [N-1:0][1:0][CW-1:0] platforms = '0;
   logic [N-1:0]             act = '0;
   logic [N-1:0][1:0]        kind = '0;
   logic [DXW-1:0]           dx = '0;
   logic [DYW-1:0]           dy = '0;
   logic                     fall = 1'b0;

   logic             busy_v [3];
   logic             done_v [3];
   logic             coll_v [3];
   logic [1:0][DYW-1:0] ground_v [3];
   logic [6:0]       idx_v [3];
   plat_kind_e       kind_v [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 93;
      collision_scanner #(.LANES(L)) u_dut (
         .clk                  (clk),
         .rst_n                (rst_n),
         .start                (start_v[g]),
         .platforms            (platforms),
         .platform_activation  (act),
         .platform_kind        (kind),
         .doodle_x             (dx),
         .doodle_y             (dy),
         .doodle_fall_direction(fall),
         .busy                 (busy_v[g]),
         .done                 (done_v[g]),
         .collision            (coll_v[g]),
         .ground               (ground_v[g]),
         .hit_index            (idx_v[g]),
         .hit_kind             (kind_v[g])
      );
   end

   int errors = 0;
   int checks = 0;
   int exp_coll, exp_gy, exp_gx, exp_idx, exp_kind;

   typedef struct {
      string name;
      int    dx, dy;
      bit    fall;
      int    slot, py, px;
      bit    act;
      int    kind;
      bit    hit;
   } vec_t;
   vec_t tbl [$];

   function automatic int scan_len(input int g);
      return (g == 0) ? 24 : (g == 1) ? 93 : 1;
   endfunction

   function automatic int pack_dut(input int g);
      return int'({coll_v[g], ground_v[g][0], ground_v[g][1], idx_v[g], kind_v[g]});
   endfunction

   function automatic int pack_exp();
      return int'({1'(exp_coll), 10'(exp_gy), 10'(exp_gx), 7'(exp_idx), 2'(exp_kind)});
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   task automatic set_exp(input int c, input int gy, input int gx, input int idx, input int k);
      exp_coll = c;
      exp_gy   = gy & 1023;
      exp_gx   = gx & 1023;
      exp_idx  = idx;
      exp_kind = k;
   endtask

   task automatic clear_field();
      act       = '0;
      platforms = '0;
      kind      = '0;
   endtask

   task automatic place(input int s, input int py, input int px, input int k);
      platforms[s][0] = CW'(py);
      platforms[s][1] = CW'(px);
      act[s]          = 1'b1;
      kind[s]         = 2'(k);
   endtask

   task automatic set_doodle(input int x, input int y, input bit f);
      dx   = DXW'(x);
      dy   = DYW'(y);
      fall = f;
   endtask

   // Reference: scan every slot, keep the smallest gap, first index wins ties.
   task automatic model_predict();
      bit found = 1'b0;
      int bg = 0, bi = 0, by = 0, bx = 0, bk = 0;
      int xi = int'(dx);
      int yi = int'(dy);
      for (int i = 0; i < N; i++) begin
         int py = int'($signed(platforms[i][0]));
         int px = int'($signed(platforms[i][1]));
         int gp = py - 50 - yi;
         if (act[i] && fall && yi >= py - 80 && yi <= py - 50 && xi >= px - 61 && xi <= px + 80) begin
            if (!found || gp < bg) begin
               found = 1'b1;
               bg = gp; bi = i; by = py; bx = px; bk = int'(kind[i]);
            end
         end
      end
      if (found) set_exp(1, by, bx, bi, bk);
      else exp_coll = 0;
   endtask

   task automatic run_scan(input string name, input bit extra);
      int done_at [3];
      int done_cnt [3];
      int busy_bad [3];
      int want = pack_exp();
      for (int g = 0; g < 3; g++) begin
         done_at[g] = -1; done_cnt[g] = 0; busy_bad[g] = 0;
         chk($sformatf("%s/d%0d idle_before", name, g), int'(busy_v[g]), 0);
      end
      @(negedge clk);
      start_v = 3'b111;
      @(posedge clk);
      for (int n = 1; n <= MAXN; n++) begin
         @(negedge clk);
         start_v = (extra && (n == 3 || n == 25)) ? 3'b001 : 3'b000;
         if (n == 1) begin
            dx   = DXW'($urandom);
            dy   = DYW'($urandom);
            fall = 1'($urandom);
         end
         for (int g = 0; g < 3; g++) begin
            if (busy_v[g] !== (n <= scan_len(g))) busy_bad[g]++;
            if (done_v[g] === 1'b1) begin
               done_cnt[g]++;
               if (done_cnt[g] == 1) begin
                  done_at[g] = n;
                  chk($sformatf("%s/d%0d result", name, g), pack_dut(g), want);
               end
            end
         end
      end
      start_v = '0;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s/d%0d done_latency", name, g), done_at[g], scan_len(g) + 1);
         chk($sformatf("%s/d%0d done_count", name, g), done_cnt[g], 1);
         chk($sformatf("%s/d%0d busy_window", name, g), busy_bad[g], 0);
         chk($sformatf("%s/d%0d hold", name, g), pack_dut(g), want);
      end
   endtask

   task automatic add_vec(input string nm, input int x, input int y, input bit f, input int s,
                          input int py, input int px, input bit a, input int k, input bit h);
      vec_t v;
      v.name = nm; v.dx = x; v.dy = y; v.fall = f; v.slot = s;
      v.py = py; v.px = px; v.act = a; v.kind = k; v.hit = h;
      tbl.push_back(v);
   endtask

   task automatic setup_single();
      clear_field();
      place(5, 160, 200, 1);
      set_doodle(200, 100, 1'b1);
      set_exp(1, 160, 200, 5, 1);
   endtask

   initial begin
      add_vec("single_hit", 200, 100, 1, 5,  160, 200, 1, 1, 1);
      add_vec("fall0",      200, 100, 0, 5,  160, 200, 1, 1, 0);
      add_vec("inactive",   200, 100, 1, 5,  160, 200, 0, 1, 0);
      add_vec("x300",       300, 100, 1, 5,  160, 200, 1, 1, 0);
      add_vec("y80",        200,  80, 1, 7,  160, 200, 1, 2, 1);
      add_vec("y110",       200, 110, 1, 9,  160, 200, 1, 3, 1);
      add_vec("y79",        200,  79, 1, 9,  160, 200, 1, 3, 0);
      add_vec("y111",       200, 111, 1, 9,  160, 200, 1, 3, 0);
      add_vec("x139",       139, 100, 1, 0,  160, 200, 1, 2, 1);
      add_vec("x280",       280, 100, 1, 92, 160, 200, 1, 3, 1);
      add_vec("x138",       138, 100, 1, 0,  160, 200, 1, 2, 0);
      add_vec("x281",       281, 100, 1, 92, 160, 200, 1, 3, 0);
      add_vec("neg_y",      200,   0, 1, 10, -20, 200, 1, 1, 0);
      add_vec("small_y",    200,   5, 1, 11,  60, 200, 1, 0, 1);
      add_vec("low_x",        0, 100, 1, 12, 160,  30, 1, 2, 1);

      // Reset state, during and just after reset.
      set_exp(0, 767, 0, 0, 0);
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("reset/d%0d outputs", g), pack_dut(g), pack_exp());
         chk($sformatf("reset/d%0d busy_done", g), int'({busy_v[g], done_v[g]}), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < 3; g++)
         chk($sformatf("post_reset/d%0d outputs", g), pack_dut(g), pack_exp());

      // Directed table.
      foreach (tbl[i]) begin
         clear_field();
         place(tbl[i].slot, tbl[i].py, tbl[i].px, tbl[i].kind);
         act[tbl[i].slot] = tbl[i].act;
         set_doodle(tbl[i].dx, tbl[i].dy, tbl[i].fall);
         if (tbl[i].hit) set_exp(1, tbl[i].py, tbl[i].px, tbl[i].slot, tbl[i].kind);
         else exp_coll = 0;
         run_scan(tbl[i].name, 1'b0);
      end

      // Nearest wins across cycles, then equal gaps fall back to lower index.
      clear_field();
      place(3, 170, 200, 1);
      place(40, 155, 200, 2);
      set_doodle(200, 100, 1'b1);
      set_exp(1, 155, 200, 40, 2);
      run_scan("nearest", 1'b0);

      clear_field();
      place(3, 155, 200, 1);
      place(40, 155, 200, 2);
      set_doodle(200, 100, 1'b1);
      set_exp(1, 155, 200, 3, 1);
      run_scan("tie_across", 1'b0);

      clear_field();
      place(41, 155, 210, 3);
      place(42, 155, 200, 0);
      place(43, 158, 200, 1);
      set_doodle(200, 100, 1'b1);
      set_exp(1, 155, 210, 41, 3);
      run_scan("tie_within", 1'b0);

      // Extra starts mid-scan and on the done cycle must be ignored.
      setup_single();
      run_scan("handshake", 1'b1);

      // Asynchronous reset in the middle of a scan.
      setup_single();
      @(negedge clk);
      start_v = 3'b111;
      @(posedge clk);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         start_v = '0;
      end
      rst_n = 1'b0;
      #1;
      set_exp(0, 767, 0, 0, 0);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("mid_reset/d%0d outputs", g), pack_dut(g), pack_exp());
         chk($sformatf("mid_reset/d%0d busy", g), int'(busy_v[g]), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int dcount = 0;
         for (int n = 0; n < MAXN; n++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) if (done_v[g] === 1'b1) dcount++;
         end
         chk("mid_reset no_done", dcount, 0);
      end
      setup_single();
      run_scan("after_reset", 1'b0);

      // Randomised fields against the reference model.
      for (int t = 0; t < 40; t++) begin
         clear_field();
         set_doodle($urandom_range(0, 600), $urandom_range(0, 400), $urandom_range(0, 7) != 0);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               int ry = $urandom_range(20, 110);
               int rx = $urandom_range(0, 160);
               place(i, int'(dy) + ry, int'(dx) + rx - 70, $urandom_range(0, 3));
            end else begin
               platforms[i] = 22'($urandom);
            end
         end
         model_predict();
         run_scan($sformatf("rand%0d", t), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
